// File: rtl/tin_psum_acc.sv
// tin_psum_acc: accumulates a job of signed Tin-group partial sums and
// delivers one saturated result through a valid/ready output handshake.
// The reduction-tree depth comes from the shared CNN defines; a fallback
// keeps the block self-contained when that header is not in the build.

`ifndef log2_Tin
`define log2_Tin 4
`endif

module tin_psum_acc #(
  parameter int DATA_WIDTH = 256,
  parameter int GUARD      = 8,
  parameter int OUT_WIDTH  = 32,
  localparam int IN_W      = DATA_WIDTH + `log2_Tin,
  localparam int ACC_W     = IN_W + GUARD
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic [7:0]                  i_groups,
  input  logic                        i_valid,
  input  logic signed [IN_W-1:0]      i_dat,
  output logic                        i_ready,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic signed [OUT_WIDTH-1:0] o_dat,
  output logic                        o_sat,
  output logic                        o_busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // Saturation limits, both at full accumulator width and at output width
  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [1:0]               state;
  logic [7:0]               cnt;
  logic                     first;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  dat_ext;
  logic signed [ACC_W-1:0]  sum_next;
  logic signed [OUT_WIDTH-1:0] sat_res;
  logic                     sat_flag;
  logic                     beat;

  assign i_ready = (state == ACC);
  assign o_busy  = (state != IDLE);
  assign beat    = i_valid && i_ready;

  // Running sum including the current beat, and its clipped output form
  always_comb begin
    dat_ext  = {{GUARD{i_dat[IN_W-1]}}, i_dat};
    sum_next = first ? dat_ext : (acc + dat_ext);
    sat_res  = sum_next[OUT_WIDTH-1:0];
    sat_flag = 1'b0;
    if (sum_next > ACC_MAX) begin
      sat_res  = OUT_MAX;
      sat_flag = 1'b1;
    end else if (sum_next < ACC_MIN) begin
      sat_res  = OUT_MIN;
      sat_flag = 1'b1;
    end
  end

  // Job control: open on start, accumulate beats, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      first   <= 1'b0;
      acc     <= '0;
      o_valid <= 1'b0;
      o_dat   <= '0;
      o_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state <= ACC;
            cnt   <= (i_groups == 8'd0) ? 8'd1 : i_groups;
            first <= 1'b1;
          end
        end
        ACC: begin
          if (beat) begin
            acc   <= sum_next;
            first <= 1'b0;
            cnt   <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              state   <= HOLD;
              o_valid <= 1'b1;
              o_dat   <= sat_res;
              o_sat   <= sat_flag;
            end
          end
        end
        HOLD: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tin_psum_acc.sv
// Directed self-checking bench for tin_psum_acc with a 16-bit lane,
// four tree levels, 8 guard bits and a 16-bit saturated result.

module tb_tin_psum_acc;

  localparam int IN_W = 20;

  logic              clk;
  logic              rst_n;
  logic              i_start;
  logic [7:0]        i_groups;
  logic              i_valid;
  logic signed [IN_W-1:0] i_dat;
  logic              i_ready;
  logic              o_valid;
  logic              o_ready;
  logic signed [15:0] o_dat;
  logic              o_sat;
  logic              o_busy;

  int vectors = 0;
  int errors  = 0;

  tin_psum_acc #(
    .DATA_WIDTH(16),
    .GUARD(8),
    .OUT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(i_start),
    .i_groups(i_groups),
    .i_valid(i_valid),
    .i_dat(i_dat),
    .i_ready(i_ready),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o_dat(o_dat),
    .o_sat(o_sat),
    .o_busy(o_busy)
  );

  // Free-running clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Open a job: i_start held for exactly one rising edge
  task automatic start_job(input logic [7:0] groups);
    i_start  = 1'b1;
    i_groups = groups;
    @(negedge clk);
    i_start  = 1'b0;
    i_groups = 8'd0;
  endtask

  // Present one beat for one rising edge
  task automatic send_beat(input int value);
    i_valid = 1'b1;
    i_dat   = value;
    @(negedge clk);
    i_valid = 1'b0;
    i_dat   = '0;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    i_start = 1'b0; i_groups = 8'd0; i_valid = 1'b0; i_dat = '0; o_ready = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({o_valid, o_sat, i_ready, o_busy} !== 4'b0000 || o_dat !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b sat=%b ready=%b busy=%b dat=%0d, want all 0",
               o_valid, o_sat, i_ready, o_busy, o_dat);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    o_ready = 1'b1;
    start_job(8'd3);
    vectors++;
    if (i_ready !== 1'b1 || o_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_acc_state: got ready=%b busy=%b, want 1 1", i_ready, o_busy);
    end
    send_beat(100);
    send_beat(-30);
    vectors++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_early_valid: got %b want 0", o_valid);
    end
    send_beat(7);
    vectors++;
    if (o_valid !== 1'b1 || o_dat !== 16'sd77 || o_sat !== 1'b0 || i_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_result: got valid=%b dat=%0d sat=%b ready=%b, want 1 77 0 0",
               o_valid, o_dat, o_sat, i_ready);
    end
    @(negedge clk);
    vectors++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_dat !== 16'sd77) begin
      errors++;
      $display("[TB] FAIL basic_handshake: got valid=%b busy=%b dat=%0d, want 0 0 77",
               o_valid, o_busy, o_dat);
    end
  endtask

  task automatic test_gaps_backpressure;
    o_ready = 1'b0;
    start_job(8'd2);
    send_beat(5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL gap_cycle%0d: got ready=%b valid=%b, want 1 0", i, i_ready, o_valid);
      end
    end
    send_beat(6);
    i_valid = 1'b1;
    i_dat   = 99;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (o_valid !== 1'b1 || o_dat !== 16'sd11 || i_ready !== 1'b0 || o_busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: got valid=%b dat=%0d ready=%b busy=%b, want 1 11 0 1",
                 i, o_valid, o_dat, i_ready, o_busy);
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_dat   = '0;
    o_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_dat !== 16'sd11) begin
      errors++;
      $display("[TB] FAIL hold_release: got valid=%b busy=%b dat=%0d, want 0 0 11",
               o_valid, o_busy, o_dat);
    end
  endtask

  task automatic test_saturation;
    o_ready = 1'b0;
    start_job(8'd4);
    for (int i = 0; i < 4; i++) send_beat(20000);
    vectors++;
    if (o_valid !== 1'b1 || o_dat !== 16'sh7FFF || o_sat !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_pos: got valid=%b dat=%0d sat=%b, want 1 32767 1", o_valid, o_dat, o_sat);
    end
    o_ready = 1'b1;
    @(negedge clk);
    start_job(8'd4);
    for (int i = 0; i < 4; i++) send_beat(-20000);
    vectors++;
    if (o_valid !== 1'b1 || o_dat !== 16'sh8000 || o_sat !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sat_neg: got valid=%b dat=%0d sat=%b, want 1 -32768 1", o_valid, o_dat, o_sat);
    end
    @(negedge clk);
  endtask

  task automatic test_boundaries;
    o_ready = 1'b1;
    start_job(8'd0);
    send_beat(-42);
    vectors++;
    if (o_valid !== 1'b1 || o_dat !== -16'sd42 || o_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL groups_zero: got valid=%b dat=%0d sat=%b, want 1 -42 0", o_valid, o_dat, o_sat);
    end
    @(negedge clk);

    start_job(8'd255);
    for (int i = 0; i < 254; i++) send_beat(1);
    vectors++;
    if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL groups_255_early: got valid=%b ready=%b, want 0 1", o_valid, i_ready);
    end
    send_beat(1);
    vectors++;
    if (o_valid !== 1'b1 || o_dat !== 16'sd255) begin
      errors++;
      $display("[TB] FAIL groups_255: got valid=%b dat=%0d, want 1 255", o_valid, o_dat);
    end
    @(negedge clk);

    start_job(8'd3);
    send_beat(10);
    start_job(8'd1);
    send_beat(20);
    vectors++;
    if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_in_acc: got valid=%b ready=%b, want 0 1", o_valid, i_ready);
    end
    send_beat(30);
    vectors++;
    if (o_valid !== 1'b1 || o_dat !== 16'sd60) begin
      errors++;
      $display("[TB] FAIL start_in_acc_sum: got valid=%b dat=%0d, want 1 60", o_valid, o_dat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_job;
    o_ready = 1'b1;
    start_job(8'd3);
    send_beat(1000);
    send_beat(2000);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({o_valid, o_sat, i_ready, o_busy} !== 4'b0000 || o_dat !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got valid=%b sat=%b ready=%b busy=%b dat=%0d, want all 0",
               o_valid, o_sat, i_ready, o_busy, o_dat);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    start_job(8'd1);
    send_beat(9);
    vectors++;
    if (o_valid !== 1'b1 || o_dat !== 16'sd9 || o_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_reset_job: got valid=%b dat=%0d sat=%b, want 1 9 0", o_valid, o_dat, o_sat);
    end
    @(negedge clk);
  endtask

  // Scenario sequence
  initial begin
    test_reset;
    test_basic;
    test_gaps_backpressure;
    test_saturation;
    test_boundaries;
    test_reset_mid_job;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/tin_psum_acc.md
TIN_PSUM_ACC -- requirements
Module: tin_psum_acc

Interface
REQ-001 Parameter DATA_WIDTH, default 256: width of one lane operand feeding the Tin reduction tree.
REQ-002 Parameter GUARD, default 8: extra accumulator headroom bits beyond the tree output width.
REQ-003 Parameter OUT_WIDTH, default 32: width of the saturated result.
REQ-004 Derived IN_W = DATA_WIDTH+`log2_Tin and ACC_W = IN_W+GUARD; `Tin and `log2_Tin come from CNN_defines.vh.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_start  input  1  one-cycle pulse that opens a job.
REQ-008 i_groups  input  8  number of Tin-group beats in the job, sampled with i_start.
REQ-009 i_valid  input  1  beat valid.
REQ-010 i_dat  input  IN_W  signed reduced partial sum for one Tin group.
REQ-011 i_ready  output  1  block accepts a beat this cycle.
REQ-012 o_valid  output  1  result valid.
REQ-013 o_ready  input  1  downstream accepts the result.
REQ-014 o_dat  output  OUT_WIDTH  signed saturated accumulated sum.
REQ-015 o_sat  output  1  o_dat was clipped.
REQ-016 o_busy  output  1  job in progress (state not IDLE).

Function
REQ-017 FSM states: IDLE, ACC, HOLD.
REQ-018 IDLE: i_ready=0; i_start moves to ACC, loads beat counter with i_groups, and treats i_groups=0 as 1.
REQ-019 ACC: i_ready=1; a beat is accepted when i_valid && i_ready.
REQ-020 Accepted beat handling: sign-extend i_dat to ACC_W; the first beat of a job loads the accumulator; each later beat adds to it, wrapping modulo 2^ACC_W.
REQ-021 Each accepted beat decrements the counter; cycles without a beat hold all state.
REQ-022 Last beat accepted at edge t: at edge t the block registers the saturated final sum into o_dat, registers o_sat, sets o_valid=1 and enters HOLD, so o_valid is high from edge t through cycle t+1 (one-cycle latency).
REQ-023 Saturation: if final ACC_W sum > 2^(OUT_WIDTH-1)-1, o_dat = that max and o_sat=1; if < -2^(OUT_WIDTH-1), o_dat = that min and o_sat=1; otherwise o_dat = sum and o_sat=0.
REQ-024 HOLD: i_ready=0; o_dat, o_sat and o_valid stay stable until o_valid && o_ready.
REQ-025 On the o_valid && o_ready handshake: o_valid drops at the next edge, state returns to IDLE, and o_dat and o_sat keep their last values.
REQ-026 i_start while in ACC or HOLD is ignored; i_groups is not resampled.
REQ-027 i_start in the same cycle as the HOLD handshake is ignored; a new job needs i_start while in IDLE.
REQ-028 i_valid while in IDLE or HOLD is not accepted and has no effect.
REQ-029 o_busy is 1 in ACC and HOLD, 0 in IDLE.

Reset
REQ-030 rst_n low, asynchronously: state=IDLE, counter=0, accumulator=0, o_valid=0, o_dat=0, o_sat=0, i_ready=0, o_busy=0.
REQ-031 rst_n asserted mid-job, in ACC or HOLD, aborts the job with no result emitted; the first job after release behaves as if no prior job occurred.
REQ-032 Reset release is not required to be synchronized internally; the bench drives release off the clock edge.

Verification (bench DATA_WIDTH=16, `log2_Tin=4, GUARD=8, OUT_WIDTH=16)
REQ-033 Basic: i_groups=3, beats 100, -30, 7 back-to-back, o_ready=1 -> o_valid one cycle after the 3rd beat, o_dat=77, o_sat=0, then IDLE.
REQ-034 Gaps and backpressure: i_groups=2, beats 5 and 6 with 3 idle cycles between, o_ready=0 for 4 cycles -> i_ready=0 in HOLD, o_dat=11 stable throughout, single handshake.
REQ-035 Saturation: i_groups=4, beats 4 x 20000 -> o_dat=32767, o_sat=1; beats 4 x -20000 -> o_dat=-32768, o_sat=1.
REQ-036 Boundaries: i_groups=0 with a single beat -42 -> o_dat=-42; i_groups=255 with beats of 1 -> o_dat=255; i_start pulsed during ACC -> ignored, counter unaffected.
REQ-037 Reset mid-operation: rst_n low after 2 of 3 beats -> all outputs 0 immediately; next job i_groups=1, beat 9 -> o_dat=9, with no residue from the aborted job.
